// File: rtl/branch_cmp_pred_pkg.sv
// Shared definitions for the branch compare/predict unit: branch op codes,
// predictor reset value and small decode/counter helpers.
package branch_cmp_pred_pkg;

    localparam logic [3:0] BOP_BEQ    = 4'b0001;
    localparam logic [3:0] BOP_BNE    = 4'b0010;
    localparam logic [3:0] BOP_BLEZ   = 4'b0011;
    localparam logic [3:0] BOP_BGTZ   = 4'b0100;
    localparam logic [3:0] BOP_BLTZ   = 4'b0101;
    localparam logic [3:0] BOP_BGEZ   = 4'b0110;
    localparam logic [3:0] BOP_BGEZAL = 4'b0111;
    localparam logic [3:0] BOP_BLTU   = 4'b1000;
    localparam logic [3:0] BOP_BGEU   = 4'b1001;

    localparam logic [1:0] PHT_RESET = 2'b01;

    // 2-bit saturating counter step toward taken (up=1) or not-taken (up=0)
    function automatic logic [1:0] cnt2_update(input logic [1:0] cnt, input logic up);
        logic [1:0] res;
        res = cnt;
        if (up) begin
            if (cnt != 2'b11) res = cnt + 2'b01;
            else              res = cnt;
        end else begin
            if (cnt != 2'b00) res = cnt - 2'b01;
            else              res = cnt;
        end
        return res;
    endfunction

    function automatic logic is_branch(input logic [3:0] bop);
        logic res;
        case (bop)
            BOP_BEQ, BOP_BNE, BOP_BLEZ, BOP_BGTZ, BOP_BLTZ,
            BOP_BGEZ, BOP_BGEZAL, BOP_BLTU, BOP_BGEU: res = 1'b1;
            default:                                   res = 1'b0;
        endcase
        return res;
    endfunction

    function automatic logic uses_zero_operand(input logic [3:0] bop);
        logic res;
        case (bop)
            BOP_BLEZ, BOP_BGTZ, BOP_BLTZ, BOP_BGEZ, BOP_BGEZAL: res = 1'b1;
            default:                                           res = 1'b0;
        endcase
        return res;
    endfunction

    function automatic logic is_unsigned_op(input logic [3:0] bop);
        logic res;
        case (bop)
            BOP_BLTU, BOP_BGEU: res = 1'b1;
            default:            res = 1'b0;
        endcase
        return res;
    endfunction

    function automatic logic branch_taken(input logic [3:0] bop, input logic more,
                                          input logic zero, input logic less);
        logic res;
        case (bop)
            BOP_BEQ:                       res = zero;
            BOP_BNE:                       res = ~zero;
            BOP_BLEZ:                      res = less | zero;
            BOP_BGTZ:                      res = more;
            BOP_BLTZ, BOP_BLTU:            res = less;
            BOP_BGEZ, BOP_BGEZAL, BOP_BGEU: res = more | zero;
            default:                       res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/branch_cmp_pred_if.sv
// Request/result bundle between the ID stage and the branch compare/predict unit.
interface branch_cmp_pred_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      pc;
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] d2;
    logic [3:0]       bop;
    logic             pred_taken;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic             taken;
    logic             more;
    logic             zero;
    logic             less;
    logic             mispredict;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    modport master (
        output in_valid, pc, d1, d2, bop, flush, out_ready,
        input  in_ready, pred_taken, out_valid, taken, more, zero, less,
               mispredict, branch_cnt, mispred_cnt
    );

    modport slave (
        input  in_valid, pc, d1, d2, bop, flush, out_ready,
        output in_ready, pred_taken, out_valid, taken, more, zero, less,
               mispredict, branch_cnt, mispred_cnt
    );
endinterface

// File: rtl/branch_cmp_pred_bcmp_core.sv
// Combinational WIDTH-bit magnitude compare producing one-hot more/zero/less,
// signed or unsigned selectable.
module bcmp_core #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             more,
    output logic             zero,
    output logic             less
);
    logic [WIDTH-1:0] a_x_s;
    logic [WIDTH-1:0] b_x_s;

    // Flipping the sign bits turns a two's-complement compare into an unsigned one
    always_comb begin
        a_x_s = {a[WIDTH-1] ^ is_signed, a[WIDTH-2:0]};
        b_x_s = {b[WIDTH-1] ^ is_signed, b[WIDTH-2:0]};
        zero  = (a == b);
        less  = (a_x_s < b_x_s);
        more  = ~less & ~zero;
    end
endmodule

// File: rtl/branch_cmp_pred.sv
// Branch compare/resolve unit with PC-indexed 2-bit predictor table, one result
// stage with valid/ready handshake, flush and branch/mispredict statistics.
module branch_cmp_pred
    import branch_cmp_pred_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int PHT_DEPTH = 64,
    parameter int CNT_W     = 32
) (
    input logic              clk,
    input logic              reset,
    branch_cmp_pred_if.slave bus
);
    localparam int IDX_W = $clog2(PHT_DEPTH);

    logic [1:0]       pht_q [PHT_DEPTH];
    logic [1:0]       pht_d [PHT_DEPTH];
    logic             out_valid_q, out_valid_d;
    logic             taken_q, taken_d;
    logic             more_q, more_d;
    logic             zero_q, zero_d;
    logic             less_q, less_d;
    logic             mispredict_q, mispredict_d;
    logic             is_br_q, is_br_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

    logic [IDX_W-1:0] rd_idx_s;
    logic [WIDTH-1:0] operand_b_s;
    logic             cmp_more_s, cmp_zero_s, cmp_less_s;
    logic             in_ready_s, accept_s, consume_s, update_s, pred_s;
    logic [1:0]       upd_cnt_s;
    logic             unused_pc_bits_s;

    assign rd_idx_s         = bus.pc[IDX_W+1:2];
    assign unused_pc_bits_s = ^{bus.pc[31:IDX_W+2], bus.pc[1:0]};
    assign operand_b_s      = uses_zero_operand(bus.bop) ? {WIDTH{1'b0}} : bus.d2;

    bcmp_core #(.WIDTH(WIDTH)) u_cmp (
        .a         (bus.d1),
        .b         (operand_b_s),
        .is_signed (~is_unsigned_op(bus.bop)),
        .more      (cmp_more_s),
        .zero      (cmp_zero_s),
        .less      (cmp_less_s)
    );

    // Handshake decode; the prediction bypasses the counter being written this cycle
    always_comb begin
        in_ready_s = ~out_valid_q | bus.out_ready;
        accept_s   = bus.in_valid & in_ready_s & ~bus.flush;
        consume_s  = out_valid_q & bus.out_ready & ~bus.flush;
        update_s   = consume_s & is_br_q;
        upd_cnt_s  = cnt2_update(pht_q[idx_q], taken_q);
        if (update_s && (idx_q == rd_idx_s)) pred_s = upd_cnt_s[1];
        else                                 pred_s = pht_q[rd_idx_s][1];
    end

    // Next-state for the result register, predictor table and statistics
    always_comb begin
        pht_d         = pht_q;
        out_valid_d   = out_valid_q;
        taken_d       = taken_q;
        more_d        = more_q;
        zero_d        = zero_q;
        less_d        = less_q;
        mispredict_d  = mispredict_q;
        is_br_d       = is_br_q;
        idx_d         = idx_q;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;

        if (update_s) begin
            pht_d[idx_q] = upd_cnt_s;
            branch_cnt_d = branch_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (mispredict_q) mispred_cnt_d = mispred_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            else              mispred_cnt_d = mispred_cnt_q;
        end else begin
            pht_d[idx_q] = pht_q[idx_q];
        end

        if (bus.flush) begin
            out_valid_d = 1'b0;
        end else if (accept_s) begin
            out_valid_d  = 1'b1;
            more_d       = cmp_more_s;
            zero_d       = cmp_zero_s;
            less_d       = cmp_less_s;
            is_br_d      = is_branch(bus.bop);
            idx_d        = rd_idx_s;
            taken_d      = branch_taken(bus.bop, cmp_more_s, cmp_zero_s, cmp_less_s);
            mispredict_d = is_branch(bus.bop) &
                           (branch_taken(bus.bop, cmp_more_s, cmp_zero_s, cmp_less_s) != pred_s);
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PHT_DEPTH; i++) pht_q[i] <= PHT_RESET;
            out_valid_q   <= 1'b0;
            taken_q       <= 1'b0;
            more_q        <= 1'b0;
            zero_q        <= 1'b0;
            less_q        <= 1'b0;
            mispredict_q  <= 1'b0;
            is_br_q       <= 1'b0;
            idx_q         <= {IDX_W{1'b0}};
            branch_cnt_q  <= {CNT_W{1'b0}};
            mispred_cnt_q <= {CNT_W{1'b0}};
        end else begin
            pht_q         <= pht_d;
            out_valid_q   <= out_valid_d;
            taken_q       <= taken_d;
            more_q        <= more_d;
            zero_q        <= zero_d;
            less_q        <= less_d;
            mispredict_q  <= mispredict_d;
            is_br_q       <= is_br_d;
            idx_q         <= idx_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign bus.in_ready    = in_ready_s;
    assign bus.pred_taken  = pred_s;
    assign bus.out_valid   = out_valid_q;
    assign bus.taken       = taken_q;
    assign bus.more        = more_q;
    assign bus.zero        = zero_q;
    assign bus.less        = less_q;
    assign bus.mispredict  = mispredict_q;
    assign bus.branch_cnt  = branch_cnt_q;
    assign bus.mispred_cnt = mispred_cnt_q;
endmodule
